// File: rtl/dht11_responder.sv
`default_nettype none
// ============================================================================
// dht11_responder : DHT11 sensor-side emulator (start detect, ack, 40-bit frame)
// Revision        : 1.0
// ============================================================================
module dht11_responder #(
  parameter int unsigned START_LOW_MIN = 900_000,
  parameter int unsigned WAIT_HOST     = 1_500,
  parameter int unsigned RESP_LOW      = 4_000,
  parameter int unsigned RESP_HIGH     = 4_000,
  parameter int unsigned BIT_LOW       = 2_500,
  parameter int unsigned BIT0_HIGH     = 1_300,
  parameter int unsigned BIT1_HIGH     = 3_500,
  parameter int unsigned END_LOW       = 2_500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        line_in,
  input  logic [39:0] data_in,
  output logic        line_oe,
  output logic        busy,
  output logic        done,
  output logic        ignored_start
);

  // Phases end when the counter reaches length-1, so each lasts exactly its length.
  localparam logic [19:0] START_MIN      = 20'(START_LOW_MIN);
  localparam logic [19:0] WAIT_LAST      = 20'(WAIT_HOST - 1);
  localparam logic [19:0] RESP_LOW_LAST  = 20'(RESP_LOW - 1);
  localparam logic [19:0] RESP_HIGH_LAST = 20'(RESP_HIGH - 1);
  localparam logic [19:0] BIT_LOW_LAST   = 20'(BIT_LOW - 1);
  localparam logic [19:0] BIT0_LAST      = 20'(BIT0_HIGH - 1);
  localparam logic [19:0] BIT1_LAST      = 20'(BIT1_HIGH - 1);
  localparam logic [19:0] END_LAST       = 20'(END_LOW - 1);
  localparam logic [19:0] CNT_MAX        = 20'hF_FFFF;
  localparam logic [5:0]  LAST_BIT       = 6'd39;

  typedef enum logic [3:0] {
    IDLE, HOST_LOW, WAIT_H, ACK_L, ACK_H, BIT_L, BIT_H, END_L, WAIT_IDLE
  } state_t;

  state_t      state, state_n;
  logic        sync_a, sync_b, s;
  logic [19:0] counter, counter_n;
  logic [5:0]  index, index_n;
  logic [39:0] data_q, data_n;
  logic        oe_n, busy_n, done_n, ign_n;
  logic [19:0] high_last;

  assign s         = sync_b;
  assign high_last = data_q[index] ? BIT1_LAST : BIT0_LAST;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a        <= 1'b1;
      sync_b        <= 1'b1;
      state         <= IDLE;
      counter       <= '0;
      index         <= '0;
      data_q        <= '0;
      line_oe       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ignored_start <= 1'b0;
    end else begin
      sync_a        <= line_in;
      sync_b        <= sync_a;
      state         <= state_n;
      counter       <= counter_n;
      index         <= index_n;
      data_q        <= data_n;
      line_oe       <= oe_n;
      busy          <= busy_n;
      done          <= done_n;
      ignored_start <= ign_n;
    end
  end

  always_comb begin
    state_n = state;
    index_n = index;
    data_n  = data_q;
    done_n  = 1'b0;
    ign_n   = 1'b0;

    case (state)
      IDLE:      if (!s) state_n = HOST_LOW;
      HOST_LOW: begin
        if (s) begin
          if (counter >= START_MIN) begin
            state_n = WAIT_H;
            data_n  = data_in;
          end else begin
            state_n = IDLE;
            ign_n   = 1'b1;
          end
        end
      end
      WAIT_H:    if (counter == WAIT_LAST) state_n = ACK_L;
      ACK_L:     if (counter == RESP_LOW_LAST) state_n = ACK_H;
      ACK_H: begin
        if (counter == RESP_HIGH_LAST) begin
          state_n = BIT_L;
          index_n = '0;
        end
      end
      BIT_L:     if (counter == BIT_LOW_LAST) state_n = BIT_H;
      BIT_H: begin
        if (counter == high_last) begin
          if (index == LAST_BIT) begin
            state_n = END_L;
          end else begin
            state_n = BIT_L;
            index_n = index + 6'd1;
          end
        end
      end
      END_L: begin
        if (counter == END_LAST) begin
          state_n = WAIT_IDLE;
          done_n  = 1'b1;
        end
      end
      // Hold off until our own trailing low has cleared the synchronizer.
      WAIT_IDLE: if (s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase

    if (!enable) begin
      state_n = IDLE;
      done_n  = 1'b0;
      ign_n   = 1'b0;
    end

    if (state_n != state)
      counter_n = (state_n == HOST_LOW) ? 20'd1 : 20'd0;
    else if (state == HOST_LOW)
      counter_n = (counter == CNT_MAX) ? counter : counter + 20'd1;
    else if (state == IDLE || state == WAIT_IDLE)
      counter_n = '0;
    else
      counter_n = counter + 20'd1;

    oe_n   = (state_n == ACK_L) || (state_n == BIT_L) || (state_n == END_L);
    busy_n = (state_n == WAIT_H) || (state_n == ACK_L) || (state_n == ACK_H) ||
             (state_n == BIT_L)  || (state_n == BIT_H) || (state_n == END_L);
  end

endmodule
`default_nettype wire

// File: tb/tb_dht11_responder.sv
`default_nettype none
// ============================================================================
// tb_dht11_responder : randomized scoreboard bench for the DHT11 responder
// Revision           : 1.0
// ============================================================================
module tb_dht11_responder;

  localparam int START_LOW_MIN = 100;
  localparam int WAIT_HOST     = 10;
  localparam int RESP_LOW      = 20;
  localparam int RESP_HIGH     = 20;
  localparam int BIT_LOW       = 12;
  localparam int BIT0_HIGH     = 6;
  localparam int BIT1_HIGH     = 16;
  localparam int END_LOW       = 12;
  localparam int SYNC_STAGES   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        host_low = 1'b0;
  logic        line_in;
  logic [39:0] data_in = '0;
  logic        line_oe, busy, done, ignored_start;

  typedef struct {
    logic [39:0] data;
    int          rise_cyc;
    int          frame_len;
  } exp_t;

  exp_t exp_q[$];
  int   edge_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   ign_seen = 0;
  int   done_seen = 0;
  bit   prev_oe = 1'b0;
  bit   prev_busy = 1'b0;

  dht11_responder #(
    .START_LOW_MIN(START_LOW_MIN), .WAIT_HOST(WAIT_HOST),
    .RESP_LOW(RESP_LOW), .RESP_HIGH(RESP_HIGH), .BIT_LOW(BIT_LOW),
    .BIT0_HIGH(BIT0_HIGH), .BIT1_HIGH(BIT1_HIGH), .END_LOW(END_LOW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .line_in(line_in),
    .data_in(data_in), .line_oe(line_oe), .busy(busy), .done(done),
    .ignored_start(ignored_start)
  );

  // Open-drain bus with pull-up: either side may pull it low.
  always_comb line_in = !(host_low || line_oe);

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_frame_len(input logic [39:0] d);
    int n = RESP_LOW + RESP_HIGH + END_LOW;
    for (int i = 0; i < 40; i++) n += BIT_LOW + (d[i] ? BIT1_HIGH : BIT0_HIGH);
    return n;
  endfunction

  // Decode the recorded line_oe edges of one complete frame against the expectation.
  task automatic check_frame();
    exp_t        e;
    logic [39:0] got;
    int          bad_low, bad_high, lo, hi;
    check("done_pending", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("edge_count", edge_q.size(), 84);
    if (edge_q.size() != 84) return;
    got = '0; bad_low = 0; bad_high = 0;
    for (int i = 0; i < 40; i++) begin
      lo = edge_q[3 + 2*i] - edge_q[2 + 2*i];
      hi = edge_q[4 + 2*i] - edge_q[3 + 2*i];
      got[i] = (hi > (BIT0_HIGH + BIT1_HIGH) / 2);
      if (lo != BIT_LOW) bad_low++;
      if (hi != (got[i] ? BIT1_HIGH : BIT0_HIGH)) bad_high++;
    end
    check("ack_rise_cycle", edge_q[0], e.rise_cyc);
    check("ack_low_width", edge_q[1] - edge_q[0], RESP_LOW);
    check("ack_high_width", edge_q[2] - edge_q[1], RESP_HIGH);
    check("bit_low_errors", bad_low, 0);
    check("bit_high_errors", bad_high, 0);
    check("frame_data", got, e.data);
    check("end_low_width", edge_q[83] - edge_q[82], END_LOW);
    check("frame_length", edge_q[83] - edge_q[0], e.frame_len);
    check("done_with_fall", edge_q[83], cyc);
    check("busy_clear_at_done", busy, 0);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      edge_q.delete();
      prev_oe   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) edge_q.delete();
      if (line_oe != prev_oe) edge_q.push_back(cyc);
      prev_oe   = line_oe;
      prev_busy = busy;
      if (ignored_start) ign_seen++;
      if (done) begin
        done_seen++;
        check_frame();
      end
    end
  end

  task automatic host_pulse(input int len, input logic [39:0] d, input bit accept);
    exp_t e;
    data_in = d;
    @(negedge clock);
    host_low = 1'b1;
    repeat (len) @(negedge clock);
    host_low = 1'b0;
    if (accept) begin
      e.data      = d;
      e.rise_cyc  = cyc + SYNC_STAGES + WAIT_HOST + 1;
      e.frame_len = model_frame_len(d);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [39:0] rand40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic run_frame(input int len, input logic [39:0] d);
    int n;
    host_pulse(len, d, 1'b1);
    n = 0;
    while (!busy && n < 20) begin @(negedge clock); n++; end
    check("busy_after_start", busy, 1);
    data_in = rand40();  // must not disturb the latched frame
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clock); n++; end
    check("frame_completed", exp_q.size(), 0);
    exp_q.delete();
    repeat (10) @(negedge clock);
  endtask

  task automatic short_pulse(input int len);
    int ign0;
    bit act;
    ign0 = ign_seen;
    act  = 1'b0;
    host_pulse(len, rand40(), 1'b0);
    repeat (30) begin
      @(negedge clock);
      act |= (busy || line_oe);
    end
    check("ignored_start_pulses", ign_seen - ign0, 1);
    check("no_activity_short", act, 0);
  endtask

  task automatic wait_edges(input int count);
    int n = 0;
    while (edge_q.size() < count && n < 2000) begin @(negedge clock); n++; end
    check("reached_edge", edge_q.size() >= count, 1);
  endtask

  initial begin
    int done0;
    repeat (3) @(negedge clock);
    check("reset_line_oe", line_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ignored", ignored_start, 0);
    reset  = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clock);

    run_frame(150, 40'h5A_00_1E_00_78);
    short_pulse(80);
    run_frame(START_LOW_MIN + 2, 40'h00_00_00_00_00);
    run_frame($urandom_range(102, 200), 40'hFF_FF_FF_FF_FF);

    for (int i = 0; i < 6; i++) begin
      short_pulse($urandom_range(20, START_LOW_MIN - 3));
      run_frame($urandom_range(START_LOW_MIN + 2, 200), rand40());
    end

    // Drop enable during bit 17's low preamble.
    host_pulse(130, rand40(), 1'b1);
    wait_edges(37);
    repeat (3) @(negedge clock);
    done0  = done_seen;
    enable = 1'b0;
    @(negedge clock);
    check("disable_line_oe", line_oe, 0);
    check("disable_busy", busy, 0);
    void'(exp_q.pop_back());
    repeat (50) @(negedge clock);
    check("disable_no_done", done_seen - done0, 0);
    enable = 1'b1;
    repeat (5) @(negedge clock);
    run_frame(120, rand40());

    // Reset during the acknowledge low.
    host_pulse(110, rand40(), 1'b1);
    wait_edges(1);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_mid_line_oe", line_oe, 0);
    check("reset_mid_busy", busy, 0);
    check("reset_mid_done", done, 0);
    check("reset_mid_ignored", ignored_start, 0);
    reset = 1'b0;
    void'(exp_q.pop_back());
    repeat (10) @(negedge clock);
    run_frame(140, 40'hA5_3C_0F_F0_01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
